// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - Morse symbol table, gap length and FSM state encoding
// Ports: none (package). Patterns are 12 units wide, left-justified, MSB sent first,
// 1 = light on (dot = 1, dash = 111, one dark unit between elements).
package morse_pkg;

  localparam int PKG_PATTERN_W = 12;
  localparam int PKG_SYMBOLS   = 8;
  localparam int GAP_UNITS     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Codes 0..7 map to letters A..H; anything else has no pattern.
  function automatic logic [PKG_PATTERN_W-1:0] sym_pattern(input int unsigned code);
    case (code)
      0:       sym_pattern = 12'b1011_1000_0000;  // A .-
      1:       sym_pattern = 12'b1110_1010_1000;  // B -...
      2:       sym_pattern = 12'b1110_1011_1010;  // C -.-.
      3:       sym_pattern = 12'b1110_1010_0000;  // D -..
      4:       sym_pattern = 12'b1000_0000_0000;  // E .
      5:       sym_pattern = 12'b1010_1110_1000;  // F ..-.
      6:       sym_pattern = 12'b1110_1110_1000;  // G --.
      7:       sym_pattern = 12'b1010_1010_0000;  // H ....
      default: sym_pattern = '0;
    endcase
  endfunction

  function automatic int unsigned sym_length(input int unsigned code);
    case (code)
      0:       sym_length = 5;
      1:       sym_length = 9;
      2:       sym_length = 11;
      3:       sym_length = 7;
      4:       sym_length = 1;
      5:       sym_length = 9;
      6:       sym_length = 9;
      7:       sym_length = 7;
      default: sym_length = 0;
    endcase
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - loadable down-counter marking Morse unit boundaries
// Ports: clock, reset (sync, active-high); restart reloads the counter so the next
//   enabled cycle is the first clock of a unit; enable lets the counter run;
//   unit_tick is high on the last clock of each unit; unit_start on the first.
module morse_unit_timer #(
  parameter int TICKS_PER_UNIT = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic unit_tick,
  output logic unit_start
);

  localparam int CNT_W = $clog2(TICKS_PER_UNIT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS_PER_UNIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = RELOAD;
    end else if (enable) begin
      // Reloading on the terminal count keeps units back-to-back with no dead clock.
      count_d = (count_q == '0) ? RELOAD : count_q - CNT_W'(1);
    end
  end

  // With TICKS_PER_UNIT = 1 both strobes are high on every enabled clock.
  assign unit_tick  = enable && (count_q == '0);
  assign unit_start = enable && (count_q == RELOAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/morse_letter_tx.sv
// rtl/morse_letter_tx.sv - Morse letter transmitter with optional repeat
// Ports: clock, reset (sync, active-high); start + letter request a letter (IDLE only);
//   repeat_en chooses gap-and-resend at letter end; dot_dash_out is the light,
//   new_bit_out pulses on the first clock of each unit, busy covers the whole
//   letter (and gaps), done pulses on the last clock of each letter.
module morse_letter_tx
  import morse_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 25_000_000,
  parameter int NUM_SYMBOLS    = 8,
  parameter int PATTERN_W      = 12,
  parameter int SYM_W          = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [SYM_W-1:0] letter,
  input  logic             repeat_en,
  output logic             dot_dash_out,
  output logic             new_bit_out,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PATTERN_W + 1);
  localparam int GAP_W = $clog2(GAP_UNITS + 1);

  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] shift_q, shift_d;
  logic [PATTERN_W-1:0] latched_q, latched_d;
  logic [IDX_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 zero_done_q, zero_done_d;

  logic                     timer_restart;
  logic                     timer_enable;
  logic                     unit_tick;
  logic                     unit_start;
  logic                     send_done;
  logic                     last_unit;
  logic [PKG_PATTERN_W-1:0] raw_pat;
  int unsigned              raw_len;
  logic [PATTERN_W-1:0]     lookup_pat;
  logic [IDX_W-1:0]         lookup_len;

  // Table lookup, re-justified to PATTERN_W. Out-of-range codes give length 0.
  always_comb begin
    raw_pat    = sym_pattern(32'(letter));
    raw_len    = sym_length(32'(letter));
    lookup_pat = '0;
    if (32'(letter) >= NUM_SYMBOLS) begin
      raw_len = 0;
    end
    if (raw_len > PATTERN_W) begin
      raw_len = PATTERN_W;
    end
    for (int k = 0; k < PATTERN_W; k++) begin
      if (k < PKG_PATTERN_W) begin
        lookup_pat[PATTERN_W-1-k] = raw_pat[PKG_PATTERN_W-1-k];
      end
    end
    lookup_len = IDX_W'(raw_len);
  end

  assign timer_enable = (state_q != ST_IDLE);

  morse_unit_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .restart   (timer_restart),
    .enable    (timer_enable),
    .unit_tick (unit_tick),
    .unit_start(unit_start)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    latched_d     = latched_q;
    len_d         = len_q;
    idx_d         = idx_q;
    gap_d         = gap_q;
    zero_done_d   = 1'b0;
    timer_restart = 1'b0;
    send_done     = 1'b0;
    last_unit     = (idx_q == len_q - IDX_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latched_d     = lookup_pat;
          shift_d       = lookup_pat;
          len_d         = lookup_len;
          idx_d         = '0;
          timer_restart = 1'b1;
          // An empty letter still acknowledges with done but never goes busy.
          if (lookup_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (unit_tick) begin
          if (last_unit) begin
            send_done = 1'b1;
            // Reload the latched letter now so a repeat resends it unchanged.
            shift_d   = latched_q;
            idx_d     = '0;
            gap_d     = '0;
            state_d   = repeat_en ? ST_GAP : ST_IDLE;
          end else begin
            shift_d = shift_q << 1;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (unit_tick) begin
          if (gap_q == GAP_W'(GAP_UNITS - 1)) begin
            gap_d   = '0;
            state_d = ST_SEND;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign dot_dash_out = (state_q == ST_SEND) && shift_q[PATTERN_W-1];
  assign new_bit_out  = (state_q == ST_SEND) && unit_start;
  assign done         = send_done || zero_done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      latched_q   <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      latched_q   <= latched_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      zero_done_q <= zero_done_d;
    end
  end

endmodule
